// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e     : sequencing FSM states
//   ID_CPU/ID_DBG : requester identifiers used for grant_id and ownership
//   MEM_LAT_*   : legal memory read-latency range, LAT_CNT_W sized to hold the max
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DBG = 1'b1;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/dmem_arbiter_arb2.sv
// arb2: two-way winner selection for the arbiter's IDLE state.
// Ports:
//   clk, rst (async active-low), hs_i : only present with DMEM_ARB_RR_EN (pointer update)
//   cpu_valid_i, dbg_valid_i          : pending requests
//   win_valid_o                       : at least one request pending
//   win_id_o                          : winning requester (ID_CPU / ID_DBG)
// DMEM_ARB_RR_EN defined: round-robin between simultaneous requests.
// DMEM_ARB_RR_EN undefined: cpu has fixed priority.
module arb2
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic hs_i,
`endif
  input  logic cpu_valid_i,
  input  logic dbg_valid_i,
  output logic win_valid_o,
  output logic win_id_o
);

  assign win_valid_o = cpu_valid_i | dbg_valid_i;

`ifdef DMEM_ARB_RR_EN
  // Pointer favours the requester not granted last; moves only on handshake.
  logic pref_dbg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pref_dbg_q <= 1'b0;
    end else if (hs_i) begin
      pref_dbg_q <= (win_id_o == ID_CPU);
    end
  end

  always_comb begin
    if (cpu_valid_i && dbg_valid_i) begin
      win_id_o = pref_dbg_q ? ID_DBG : ID_CPU;
    end else begin
      win_id_o = cpu_valid_i ? ID_CPU : ID_DBG;
    end
  end
`else
  assign win_id_o = cpu_valid_i ? ID_CPU : ID_DBG;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the cpu load/store
// path and a debug/loader port. One request at a time: accept, issue one
// mem_en cycle, wait MEM_LAT cycles on reads, pulse the owner's rsp_valid.
// Ports:
//   clk, rst (async active-low)
//   cpu_req_* / dbg_req_* : valid/ready request (we, addr, wdata)
//   cpu_rsp_* / dbg_rsp_* : one-cycle completion pulse + held read data
//   mem_*                 : memory strobe, write enable, address, data
//   busy, grant_id        : non-IDLE flag, owner of current/last transaction
// Build option: DMEM_ARB_RR_EN selects round-robin instead of cpu priority.
// MEM_LAT legal range is MEM_LAT_MIN..MEM_LAT_MAX.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   owner_q, owner_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]      cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]      dbg_rdata_q, dbg_rdata_d;

  logic idle;
  logic win_valid;
  logic win_id;
  logic hs;

  assign idle = (state_q == IDLE);
  // rst gates the handshake so nothing is accepted before the first edge with rst high.
  assign hs   = rst & idle & win_valid;

  arb2 u_arb2 (
`ifdef DMEM_ARB_RR_EN
    .clk         (clk),
    .rst         (rst),
    .hs_i        (hs),
`endif
    .cpu_valid_i (cpu_req_valid),
    .dbg_valid_i (dbg_req_valid),
    .win_valid_o (win_valid),
    .win_id_o    (win_id)
  );

  assign cpu_req_ready = hs & (win_id == ID_CPU);
  assign dbg_req_ready = hs & (win_id == ID_DBG);

  // State and latched-transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= ID_CPU;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ISSUE;
          owner_d = win_id;
          we_d    = (win_id == ID_DBG) ? dbg_req_we    : cpu_req_we;
          addr_d  = (win_id == ID_DBG) ? dbg_req_addr  : cpu_req_addr;
          wdata_d = (win_id == ID_DBG) ? dbg_req_wdata : cpu_req_wdata;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_CNT_W'(MEM_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_CNT_W'(1);
        if (cnt_q == LAT_CNT_W'(1)) begin
          state_d = RESP;
          if (owner_q == ID_DBG) dbg_rdata_d = mem_rdata;
          else                   cpu_rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; memory bus is zeroed outside ISSUE.
  assign mem_en        = (state_q == ISSUE);
  assign mem_we        = mem_en & we_q;
  assign mem_addr      = mem_en ? addr_q  : '0;
  assign mem_wdata     = mem_en ? wdata_q : '0;
  assign cpu_rsp_valid = (state_q == RESP) & (owner_q == ID_CPU);
  assign dbg_rsp_valid = (state_q == RESP) & (owner_q == ID_DBG);
  assign cpu_rsp_rdata = cpu_rdata_q;
  assign dbg_rsp_rdata = dbg_rdata_q;
  assign busy          = ~idle;
  assign grant_id      = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: transaction-level model + per-cycle compare on a
// MEM_LAT=1 instance, directed cycle-exact checks on a MEM_LAT=4 instance.
module tb_dmem_arbiter;

  localparam int unsigned LAT  = 1;
  localparam int unsigned LAT4 = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT (MEM_LAT=1) signals
  logic        c_valid = 0, c_we = 0, d_valid = 0, d_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic        c_ready, d_ready, c_rv, d_rv;
  logic [31:0] c_rd, d_rd;
  logic        mem_en, mem_we, busy, grant_id;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // DUT (MEM_LAT=4) signals
  logic        c4_valid = 0;
  logic [31:0] c4_addr = 0;
  logic        z1 = 0;
  logic [31:0] z32 = 0;
  logic        c4_ready, d4_ready, c4_rv, d4_rv;
  logic [31:0] c4_rd, d4_rd;
  logic        mem_en4, mem_we4, busy4, grant_id4;
  logic [31:0] mem_addr4, mem_wdata4, mem_rdata4;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(c_valid), .cpu_req_ready(c_ready), .cpu_req_we(c_we),
    .cpu_req_addr(c_addr), .cpu_req_wdata(c_wdata),
    .cpu_rsp_valid(c_rv), .cpu_rsp_rdata(c_rd),
    .dbg_req_valid(d_valid), .dbg_req_ready(d_ready), .dbg_req_we(d_we),
    .dbg_req_addr(d_addr), .dbg_req_wdata(d_wdata),
    .dbg_rsp_valid(d_rv), .dbg_rsp_rdata(d_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_req_valid(c4_valid), .cpu_req_ready(c4_ready), .cpu_req_we(z1),
    .cpu_req_addr(c4_addr), .cpu_req_wdata(z32),
    .cpu_rsp_valid(c4_rv), .cpu_rsp_rdata(c4_rd),
    .dbg_req_valid(z1), .dbg_req_ready(d4_ready), .dbg_req_we(z1),
    .dbg_req_addr(z32), .dbg_req_wdata(z32),
    .dbg_rsp_valid(d4_rv), .dbg_rsp_rdata(d4_rd),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4), .grant_id(grant_id4)
  );

  // Memory stubs: read data appears MEM_LAT cycles after the strobe, junk otherwise.
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  logic [31:0] p1;
  logic [31:0] p4 [4];
  assign mem_rdata  = p1;
  assign mem_rdata4 = p4[3];

  always @(posedge clk) begin
    p1 <= (mem_en && !mem_we) ? tb_mem[mem_addr[9:2]] : (32'hBAD0_0000 ^ 32'(cyc));
    if (mem_en && mem_we) tb_mem[mem_addr[9:2]] = mem_wdata;
    p4[0] <= (mem_en4 && !mem_we4) ? tb_mem[mem_addr4[9:2]] : (32'hBAD4_0000 ^ 32'(cyc));
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A transaction occupies cycles 1..rsp_k after its accept cycle; the
  // response pulse lands on the last of them.
  bit          has_txn = 0;
  int          t_acc = 0;
  bit          m_we = 0, m_own = 0, m_grant = 0, m_pref = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0;
  logic [31:0] m_rd [2] = '{32'h0, 32'h0};
  logic [1:0]  mw;
  int          mk;

  function automatic logic [1:0] winner(input logic cv, input logic dv, input logic pref);
    if (RR_BUILD && cv && dv) return {1'b1, pref};
    return {cv | dv, cv ? 1'b0 : 1'b1};
  endfunction

  function automatic int rsp_k(input bit we);
    return we ? 2 : 2 + int'(LAT);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_txn = 0; m_rd[0] = 0; m_rd[1] = 0; m_grant = 0; m_pref = 0;
    end else if (has_txn) begin
      mk = cyc - t_acc;
      if (!m_we && mk == 1 + int'(LAT)) m_rd[m_own] = m_data;
      if (mk >= rsp_k(m_we)) has_txn = 0;
    end else begin
      mw = winner(c_valid, d_valid, m_pref);
      if (mw[1]) begin
        has_txn = 1; t_acc = cyc; m_own = mw[0]; m_grant = mw[0]; m_pref = ~mw[0];
        m_we    = mw[0] ? d_we    : c_we;
        m_addr  = mw[0] ? d_addr  : c_addr;
        m_wdata = mw[0] ? d_wdata : c_wdata;
        if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
        else      m_data = ref_mem[m_addr[9:2]];
      end
    end
  end

  // Per-cycle compare of the MEM_LAT=1 instance against the model.
  always @(negedge clk) begin
    int k;
    logic [1:0] w;
    bit en;
    k  = cyc - t_acc;
    w  = winner(c_valid, d_valid, m_pref);
    en = has_txn && k == 1;
    chk("cpu_req_ready", c_ready, rst && !has_txn && w[1] && !w[0]);
    chk("dbg_req_ready", d_ready, rst && !has_txn && w[1] && w[0]);
    chk("mem_en", mem_en, en);
    chk("mem_we", mem_we, en && m_we);
    chk("mem_addr", mem_addr, en ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata, en ? m_wdata : 32'h0);
    chk("cpu_rsp_valid", c_rv, has_txn && k == rsp_k(m_we) && !m_own);
    chk("dbg_rsp_valid", d_rv, has_txn && k == rsp_k(m_we) && m_own);
    chk("cpu_rsp_rdata", c_rd, m_rd[0]);
    chk("dbg_rsp_rdata", d_rd, m_rd[1]);
    chk("busy", busy, has_txn);
    chk("grant_id", grant_id, m_grant);
  end

  // ---------------- directed stimulus ----------------
  task automatic req(input bit who, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, output int acc);
    bit got;
    got = 0; acc = -1;
    if (who) begin d_valid = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else     begin c_valid = 1; c_we = we; c_addr = addr; c_wdata = wdata; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (who ? d_ready : c_ready) begin
        acc = cyc; got = 1;
        @(posedge clk); #1;
        if (who) d_valid = 0; else c_valid = 0;
      end
    end
    chk("req_accepted", got, 1'b1);
  endtask

  task automatic wait_rsp(input bit who, output int rc, output logic [31:0] rd);
    bit got;
    got = 0; rc = -1; rd = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (who ? d_rv : c_rv) begin rc = cyc; rd = who ? d_rd : c_rd; got = 1; end
    end
    chk("rsp_seen", got, 1'b1);
  endtask

  int          acc, rc, ng, cnt;
  logic [31:0] rd;
  bit          gc, gd;
  int          ord [5];
  int          exp_ord [5];

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    tb_mem[8'h04]  = 32'hDEAD_BEEF; ref_mem[8'h04]  = 32'hDEAD_BEEF;
    tb_mem[8'h10]  = 32'hCAFE_F00D; ref_mem[8'h10]  = 32'hCAFE_F00D;
    if (RR_BUILD) exp_ord = '{0, 1, 0, 1, 1};
    else          exp_ord = '{0, 0, 0, 0, 1};

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_cpu_rdata", c_rd, 32'h0);
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #1;

    // cpu read 0x10, MEM_LAT=1
    req(0, 0, 32'h10, 32'h0, acc);
    @(negedge clk);
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    wait_rsp(0, rc, rd);
    chk("t1_rsp_cycle", rc, acc + 3);
    chk("t1_rdata", rd, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // dbg write 0x20 <- 0x12345678
    req(1, 1, 32'h20, 32'h1234_5678, acc);
    @(negedge clk);
    chk("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h20);
    chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t2_busy_a1", busy, 1'b1);
    wait_rsp(1, rc, rd);
    chk("t2_rsp_cycle", rc, acc + 2);
    chk("t2_busy_a2", busy, 1'b1);
    @(posedge clk); #1;

    // Both valids held: grant order
    c_valid = 1; c_we = 0; c_addr = 32'h100;
    d_valid = 1; d_we = 0; d_addr = 32'h180;
    ng = 0;
    for (int i = 0; i < 80 && ng < 5; i++) begin
      @(negedge clk);
      gc = c_ready && c_valid;
      gd = d_ready && d_valid;
      @(posedge clk); #1;
      if (gc) begin ord[ng] = 0; ng++; c_addr += 32'h4; end
      if (gd) begin ord[ng] = 1; ng++; d_addr += 32'h4; end
      if (ng >= 4) c_valid = 0;
      if (ng >= 5) d_valid = 0;
    end
    chk("t3_grants", ng, 5);
    for (int i = 0; i < 5; i++) chk("t3_order", ord[i], exp_ord[i]);
    repeat (6) @(posedge clk); #1;

    // Read back the dbg write through the cpu port
    req(0, 0, 32'h20, 32'h0, acc);
    wait_rsp(0, rc, rd);
    chk("t2_readback", rd, 32'h1234_5678);
    @(posedge clk); #1;

    // MEM_LAT=4 read on second instance
    c4_valid = 1; c4_addr = 32'h40;
    @(negedge clk);
    chk("t4_ready", c4_ready, 1'b1);
    @(posedge clk); #1 c4_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t4_mem_en", mem_en4, k == 1);
      chk("t4_rsp_valid", c4_rv, k == 6);
      chk("t4_busy", busy4, k <= 6);
      chk("t4_rdata", c4_rd, (k >= 6) ? 32'hCAFE_F00D : 32'h0);
    end
    @(posedge clk); #1;

    // Reset during WAIT of a read
    req(0, 0, 32'h10, 32'h0, acc);
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rdata", c_rd, 32'h0);
    @(posedge clk); #3 rst = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (c_rv || d_rv) cnt++;
    end
    chk("t5_no_rsp", cnt, 0);
    @(posedge clk); #1;
    req(0, 0, 32'h10, 32'h0, acc);
    wait_rsp(0, rc, rd);
    chk("t5_after_rsp_cycle", rc, acc + 3);
    chk("t5_after_rdata", rd, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // dbg valid pulsed for one cycle while busy
    req(0, 1, 32'h30, 32'h55, acc);
    @(posedge clk); #1;
    d_valid = 1; d_we = 0; d_addr = 32'h24;
    @(negedge clk);
    chk("t6_dbg_ready", d_ready, 1'b0);
    @(posedge clk); #1 d_valid = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_en) cnt++;
    end
    chk("t6_no_mem_en", cnt, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing controller that shares the single-port data memory between two requesters: the processor load/store path (cpu) and a debug/loader port (dbg). It accepts one request at a time through valid/ready handshakes, drives the memory for exactly one issue cycle, waits the memory's read latency and returns a registered one-cycle response to the owning requester. It sits between the processor's ALU-result/read-data2 store path and the data memory, and lets a test harness preload or inspect memory without a separate port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal 1..4
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- cpu_req_valid / dbg_req_valid  input  1  request present
- cpu_req_ready / dbg_req_ready  output  1  request accepted this cycle
- cpu_req_we / dbg_req_we  input  1  1 = write, 0 = read
- cpu_req_addr / dbg_req_addr  input  ADDR_W  byte address, passed unchanged
- cpu_req_wdata / dbg_req_wdata  input  DATA_W  write data
- cpu_rsp_valid / dbg_rsp_valid  output  1  one-cycle completion pulse, reads and writes
- cpu_rsp_rdata / dbg_rsp_rdata  output  DATA_W  read data, valid with rsp_valid
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable, only with mem_en
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high in every state except IDLE
- grant_id  output  1  owner of current or last transaction: 0 = cpu, 1 = dbg

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: ready is asserted combinationally to the arbitration winner only, and only if its valid is high. Handshake is valid&ready at a rising edge. On handshake, we/addr/wdata and the owner are latched, grant_id is updated, and the FSM goes to ISSUE.
- ISSUE: mem_en=1 for exactly one cycle, driven from the latched fields. A write goes to RESP. A read goes to WAIT with the latency counter loaded to MEM_LAT.
- WAIT: the counter decrements each cycle. At count 1, mem_rdata is captured into the owner's rsp_rdata register and the FSM goes to RESP.
- RESP: the owner's rsp_valid=1 for one cycle, then the FSM returns to IDLE. No response backpressure; requesters must take the pulse.
- Non-owner rsp_valid stays 0. rsp_rdata holds its last value. After a write, rsp_rdata is unchanged.
- Arbitration with both valids in IDLE is set by the Configuration macro. A single valid always wins.
- Requesters hold valid and payload until ready. A valid that drops before handshake leaves no state.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_en=0.
- Reset values: FSM=IDLE, all ready/rsp_valid/mem_* = 0, rsp_rdata=0, busy=0, grant_id=0, RR pointer=cpu-preferred.

## Timing
- Handshake at edge A.
- Read: ISSUE in cycle A+1, capture at the end of cycle A+1+MEM_LAT, rsp_valid in cycle A+2+MEM_LAT.
- Write: ISSUE in A+1, rsp_valid in A+2.
- Next handshake is possible no earlier than the cycle after RESP. Peak throughput is one read per MEM_LAT+3 cycles.
- Reset asserted mid-transaction: the FSM enters IDLE immediately and asynchronously, all outputs take their reset values, the pending transaction is dropped, and no rsp_valid is produced.
- A memory write already strobed is not undone.
- Valid arriving in the same cycle reset releases: not accepted before the first clock edge with rst high.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. With both valids high, the winner is the requester not granted last. The pointer updates only on handshake.
- DMEM_ARB_RR_EN undefined: fixed priority, cpu always wins. dbg is served only when cpu_req_valid=0 in IDLE. No pointer register.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP)
  - requester ID constants ID_CPU=0, ID_DBG=1
  - latency counter width and MEM_LAT bounds
- Sub-module arb2: a 2-way grant selector with an optional RR pointer under DMEM_ARB_RR_EN. Purely the IDLE winner logic; the FSM stays in dmem_arbiter.

## Test plan
- Reset, then cpu read addr 0x10 with memory returning 0xDEADBEEF, MEM_LAT=1 -> mem_en in A+1 with addr 0x10, cpu_rsp_valid in A+3 with rdata 0xDEADBEEF, dbg_rsp_valid stays 0.
- dbg write addr 0x20 data 0x12345678 -> mem_en=mem_we=1 in A+1 with that addr/data, dbg_rsp_valid in A+2, busy high for A+1..A+2.
- Both valids held for 4 transactions -> RR build grants cpu,dbg,cpu,dbg. Fixed build grants cpu ×4 and dbg waits with ready=0.
- MEM_LAT=4 read -> rsp_valid exactly in A+6, with the captured value taken from the cycle-A+5 mem_rdata.
- rst low during WAIT of a read -> all outputs 0 immediately, no rsp_valid after release, next request handled normally.
- dbg valid pulsed for one cycle while FSM busy -> never accepted, no mem_en for it.
